command_executor: RTL and testbench

// Downstream of the SPI instruction decoder. Takes one decoded command
// (opcode/address/value) per cmd_valid_i pulse and runs it on a single-master
// req/ack memory bus. Returns read data on result_o (decoder result_i) and

---
 rtl/command_executor.sv | 253 +++++++++++++++++++++++++
 tb/tb_command_executor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_executor.sv
// -----------------------------------------------------------------------------
// command_executor
//
// Runs decoded SPI commands on a single-master req/ack memory bus. A command
// (opcode/address/value) arrives as a one-cycle cmd_valid_i pulse. Plain
// WRITE/READ issue one bus access. STREAM writes to the bound write address
// and then prefetches from the bound read address, after which both bindings
// post-increment. Bind opcodes only load an address register. Every bus
// request is guarded by a timeout. Timeouts and overruns set a sticky error
// flag, which the next accepted command clears.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   cmd_valid_i  one-cycle pulse qualifying cmd_instr_i/cmd_addr_i/cmd_value_i
//   cmd_instr_i  opcode (1 WRITE, 2 READ, 3 STREAM, 4/5/6 bind irq/rd/wr)
//   cmd_addr_i   address field
//   cmd_value_i  value field (write data)
//   busy_o       command in progress; commands arriving now are dropped
//   bus_req_o    bus request, held until ack or timeout
//   bus_we_o     1 = write, 0 = read
//   bus_addr_o   bus address
//   bus_wdata_o  bus write data
//   bus_rdata_i  bus read data, sampled in the ack cycle
//   bus_ack_i    one-cycle completion strobe from the slave
//   result_o     data of the last completed READ
//   stream_o     data of the last completed STREAM prefetch
//   irq_addr_o   bound interrupt address
//   err_o        sticky error: bus timeout or command overrun
// -----------------------------------------------------------------------------
module command_executor #(
  parameter int INSTRUCTION_WIDTH = 8,
  parameter int ADDRESS_WIDTH     = 24,
  parameter int VALUE_WIDTH       = 32,
  parameter int ADDR_INC          = 1,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  input  logic [INSTRUCTION_WIDTH-1:0] cmd_instr_i,
  input  logic [ADDRESS_WIDTH-1:0]     cmd_addr_i,
  input  logic [VALUE_WIDTH-1:0]       cmd_value_i,
  output logic                         busy_o,
  output logic                         bus_req_o,
  output logic                         bus_we_o,
  output logic [ADDRESS_WIDTH-1:0]     bus_addr_o,
  output logic [VALUE_WIDTH-1:0]       bus_wdata_o,
  input  logic [VALUE_WIDTH-1:0]       bus_rdata_i,
  input  logic                         bus_ack_i,
  output logic [VALUE_WIDTH-1:0]       result_o,
  output logic [VALUE_WIDTH-1:0]       stream_o,
  output logic [ADDRESS_WIDTH-1:0]     irq_addr_o,
  output logic                         err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_S_WR,
    ST_S_RD
  } state_t;

  localparam logic [INSTRUCTION_WIDTH-1:0] OP_WRITE    = INSTRUCTION_WIDTH'(1);
  localparam logic [INSTRUCTION_WIDTH-1:0] OP_READ     = INSTRUCTION_WIDTH'(2);
  localparam logic [INSTRUCTION_WIDTH-1:0] OP_STREAM   = INSTRUCTION_WIDTH'(3);
  localparam logic [INSTRUCTION_WIDTH-1:0] OP_BIND_IRQ = INSTRUCTION_WIDTH'(4);
  localparam logic [INSTRUCTION_WIDTH-1:0] OP_BIND_RD  = INSTRUCTION_WIDTH'(5);
  localparam logic [INSTRUCTION_WIDTH-1:0] OP_BIND_WR  = INSTRUCTION_WIDTH'(6);

  // The wait counter only ever holds 0 .. TIMEOUT_CYCLES-1.
  localparam int                         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0]   INC      = ADDRESS_WIDTH'(ADDR_INC);

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [VALUE_WIDTH-1:0]     wdata_q;
  logic [ADDRESS_WIDTH-1:0]   rd_bind_q;
  logic [ADDRESS_WIDTH-1:0]   wr_bind_q;
  logic [ADDRESS_WIDTH-1:0]   irq_addr_q;
  logic [VALUE_WIDTH-1:0]     result_q;
  logic [VALUE_WIDTH-1:0]     stream_q;
  logic                       err_q;
  logic [CNT_W-1:0]           wait_cnt_q;

  logic busy;
  logic op_known;
  logic accept;
  logic overrun;
  logic timeout;

  // ---------------------------------------------------------------------------
  // Command qualification
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    op_known = 1'b0;
    case (cmd_instr_i)
      OP_WRITE, OP_READ, OP_STREAM,
      OP_BIND_IRQ, OP_BIND_RD, OP_BIND_WR: op_known = 1'b1;
      default:                             op_known = 1'b0;
    endcase
  end

  // The request is live in every non-idle state (a timeout returns straight to
  // IDLE), so busy doubles as "request outstanding".
  assign busy    = (state_q != ST_IDLE);
  assign accept  = cmd_valid_i && !busy && op_known;
  assign overrun = cmd_valid_i && busy;
  // An ack on the limit cycle takes priority over the timeout.
  assign timeout = busy && !bus_ack_i && (wait_cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_instr_i)
            OP_WRITE:  state_d = ST_WR;
            OP_READ:   state_d = ST_RD;
            OP_STREAM: state_d = ST_S_WR;
            default:   state_d = ST_IDLE;  // bind opcodes finish on the accept edge
          endcase
        end
      end
      ST_WR, ST_RD, ST_S_RD: begin
        if (bus_ack_i || timeout) state_d = ST_IDLE;
      end
      ST_S_WR: begin
        // A timed-out stream write abandons the prefetch entirely.
        if (bus_ack_i)    state_d = ST_S_RD;
        else if (timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Stream addresses come straight from the bindings; they only change at the
  // end of S_RD or from a bind in IDLE, so they are stable while requested.
  always_comb begin
    busy_o     = busy;
    bus_req_o  = busy;
    bus_we_o   = 1'b0;
    bus_addr_o = addr_q;
    case (state_q)
      ST_WR: begin
        bus_we_o = 1'b1;
      end
      ST_S_WR: begin
        bus_we_o   = 1'b1;
        bus_addr_o = wr_bind_q;
      end
      ST_S_RD: begin
        bus_addr_o = rd_bind_q;
      end
      default: begin
        bus_we_o   = 1'b0;
        bus_addr_o = addr_q;
      end
    endcase
  end

  assign bus_wdata_o = wdata_q;
  assign result_o    = result_q;
  assign stream_o    = stream_q;
  assign irq_addr_o  = irq_addr_q;
  assign err_o       = err_q;

  // ---------------------------------------------------------------------------
  // Datapath: command capture, bindings, results, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_bind_q  <= '0;
      wr_bind_q  <= '0;
      irq_addr_q <= '0;
      result_q   <= '0;
      stream_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
        case (cmd_instr_i)
          OP_WRITE: begin
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_value_i;
          end
          OP_READ:     addr_q     <= cmd_addr_i;
          OP_STREAM:   wdata_q    <= cmd_value_i;
          OP_BIND_IRQ: irq_addr_q <= cmd_addr_i;
          OP_BIND_RD:  rd_bind_q  <= cmd_addr_i;
          OP_BIND_WR:  wr_bind_q  <= cmd_addr_i;
          default: ;
        endcase
      end

      // accept and overrun/timeout are mutually exclusive (idle vs busy).
      if (overrun || timeout) err_q <= 1'b1;

      if (state_q == ST_RD && bus_ack_i) begin
        result_q <= bus_rdata_i;
      end

      // Bindings advance only after a fully completed stream; the add wraps
      // naturally at the address width.
      if (state_q == ST_S_RD && bus_ack_i) begin
        stream_q  <= bus_rdata_i;
        rd_bind_q <= rd_bind_q + INC;
        wr_bind_q <= wr_bind_q + INC;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-request wait counter
  // ---------------------------------------------------------------------------
  // Cleared whenever a request ends (ack or timeout) so the S_RD request that
  // follows an S_WR ack starts its own budget from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (!busy || bus_ack_i || timeout) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_command_executor.sv
// -----------------------------------------------------------------------------
// tb_command_executor
//
// Self-checking bench for command_executor. A transaction-level model predicts,
// per command, how many cycles busy_o stays high, which bus accesses appear,
// and the resulting result/stream/irq/error values. A behavioural slave answers
// each request after a chosen number of wait cycles and checks the request
// fields against the model's expectation. The DUT runs with a short timeout so
// both the ack-on-the-last-cycle and the timeout paths are reachable.
// -----------------------------------------------------------------------------
module tb_command_executor;

  localparam int IW  = 8;
  localparam int AW  = 24;
  localparam int VW  = 32;
  localparam int INC = 1;
  localparam int TO  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic [IW-1:0] cmd_instr_i;
  logic [AW-1:0] cmd_addr_i;
  logic [VW-1:0] cmd_value_i;
  logic          busy_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [VW-1:0] bus_wdata_o;
  logic [VW-1:0] bus_rdata_i;
  logic          bus_ack_i;
  logic [VW-1:0] result_o;
  logic [VW-1:0] stream_o;
  logic [AW-1:0] irq_addr_o;
  logic          err_o;

  command_executor #(
    .INSTRUCTION_WIDTH (IW),
    .ADDRESS_WIDTH     (AW),
    .VALUE_WIDTH       (VW),
    .ADDR_INC          (INC),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_instr_i (cmd_instr_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_value_i (cmd_value_i),
    .busy_o      (busy_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .result_o    (result_o),
    .stream_o    (stream_o),
    .irq_addr_o  (irq_addr_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [AW-1:0] m_rd_bind, m_wr_bind, m_irq;
  logic [VW-1:0] m_result, m_stream;
  bit            m_err;

  task automatic model_reset();
    m_rd_bind = '0; m_wr_bind = '0; m_irq = '0;
    m_result  = '0; m_stream  = '0; m_err = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural slave: acks request n after s_w[n] wait cycles (zero-wait means
  // ack sampled on the second edge after the request rises) and checks the
  // request fields against the expectation set up for this command.
  // ---------------------------------------------------------------------------
  int            s_w [2];
  logic [VW-1:0] s_rd [2];
  logic [AW-1:0] exp_addr [2];
  logic          exp_we [2];
  logic [VW-1:0] exp_wdata;
  int            s_idx = 0;
  int            s_k   = 0;

  always @(negedge clk_i) begin
    if (bus_ack_i) begin
      bus_ack_i   = 1'b0;
      bus_rdata_i = $urandom;
      s_k         = 0;
      if (bus_req_o) begin
        s_idx = 1;
        s_k   = 1;
      end
    end else if (bus_req_o) begin
      s_k++;
      if (s_k == s_w[s_idx] + 2) begin
        check("bus_we", bus_we_o, exp_we[s_idx]);
        check("bus_addr", bus_addr_o, exp_addr[s_idx]);
        if (exp_we[s_idx]) check("bus_wdata", bus_wdata_o, exp_wdata);
        bus_ack_i   = 1'b1;
        bus_rdata_i = s_rd[s_idx];
      end
    end else begin
      s_k = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue one command and check the outcome. Called at a negedge, returns at a
  // negedge with the DUT idle. ovr>0 pulses a stray command ovr cycles in.
  // ---------------------------------------------------------------------------
  task automatic run_cmd(input logic [IW-1:0] op, input logic [AW-1:0] addr,
                         input logic [VW-1:0] val, input int w1, input int w2,
                         input logic [VW-1:0] r0, input logic [VW-1:0] r1,
                         input int ovr, input string tag);
    int exp_cycles;
    bit ok1, ok2, ovr_hit, done;
    int cnt;
    exp_cycles = 0;
    ok1 = (w1 + 2 <= TO);
    ok2 = (w2 + 2 <= TO);
    s_w[0] = w1; s_w[1] = w2; s_rd[0] = r0; s_rd[1] = r1; s_idx = 0;
    exp_wdata = val;
    case (op)
      8'd1, 8'd2: begin
        exp_we[0]   = (op == 8'd1);
        exp_addr[0] = addr;
        exp_cycles  = ok1 ? w1 + 2 : TO;
        m_err       = !ok1;
        if (op == 8'd2 && ok1) m_result = r0;
      end
      8'd3: begin
        exp_we[0] = 1'b1; exp_addr[0] = m_wr_bind;
        exp_we[1] = 1'b0; exp_addr[1] = m_rd_bind;
        if (!ok1) begin
          exp_cycles = TO;
          m_err      = 1'b1;
        end else begin
          exp_cycles = w1 + 2 + (ok2 ? w2 + 2 : TO);
          m_err      = !ok2;
          if (ok2) begin
            m_stream  = r1;
            m_wr_bind = m_wr_bind + AW'(INC);
            m_rd_bind = m_rd_bind + AW'(INC);
          end
        end
      end
      8'd4: begin m_irq     = addr; m_err = 1'b0; end
      8'd5: begin m_rd_bind = addr; m_err = 1'b0; end
      8'd6: begin m_wr_bind = addr; m_err = 1'b0; end
      default: ;
    endcase
    ovr_hit = (ovr >= 1) && (ovr < exp_cycles);
    if (ovr_hit) m_err = 1'b1;

    cmd_valid_i = 1'b1;
    cmd_instr_i = op;
    cmd_addr_i  = addr;
    cmd_value_i = val;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      cmd_instr_i = IW'($urandom);
      cmd_addr_i  = AW'($urandom);
      cmd_value_i = $urandom;
      if (busy_o) begin
        cnt++;
        if (ovr_hit && i == ovr) cmd_valid_i = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
    cmd_valid_i = 1'b0;
    check({tag, ".busy_cycles"}, 64'(cnt), 64'(exp_cycles));
    check({tag, ".req_idle"}, bus_req_o, 1'b0);
    check({tag, ".err"}, err_o, m_err);
    check({tag, ".result"}, result_o, m_result);
    check({tag, ".stream"}, stream_o, m_stream);
    check({tag, ".irq"}, irq_addr_o, m_irq);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy_o, 1'b0);
    check({tag, ".req"}, bus_req_o, 1'b0);
    check({tag, ".we"}, bus_we_o, 1'b0);
    check({tag, ".addr"}, bus_addr_o, '0);
    check({tag, ".wdata"}, bus_wdata_o, '0);
    check({tag, ".result"}, result_o, '0);
    check({tag, ".stream"}, stream_o, '0);
    check({tag, ".irq"}, irq_addr_o, '0);
    check({tag, ".err"}, err_o, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [IW-1:0] op;
    logic [AW-1:0] addr;
    int sel;

    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_instr_i = '0;
    cmd_addr_i  = '0;
    cmd_value_i = '0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases.
    run_cmd(8'd1, 24'h000010, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0, 0, "write_zero_wait");
    // Ack lands exactly on the last permitted request cycle.
    run_cmd(8'd2, 24'h000020, 32'h0, TO - 2, 0, 32'h12345678, 32'h0, 0, "read_ack_at_limit");
    run_cmd(8'd5, 24'hFFFFFF, 32'h0, 0, 0, 32'h0, 32'h0, 0, "bind_rd");
    run_cmd(8'd6, 24'h000100, 32'h0, 0, 0, 32'h0, 32'h0, 0, "bind_wr");
    run_cmd(8'd3, 24'h0, 32'hAABBCCDD, 0, 0, 32'h0, 32'h00000055, 0, "stream");
    // Second stream exposes the incremented bindings: wr 0x101, rd wrapped to 0.
    run_cmd(8'd3, 24'h0, 32'h01020304, 1, 0, 32'h0, 32'h00000066, 0, "stream_wrap");
    run_cmd(8'd4, 24'h00ABCD, 32'h0, 0, 0, 32'h0, 32'h0, 0, "bind_irq");

    // Asynchronous reset while a WRITE request is outstanding.
    s_w[0] = 3; s_idx = 0;
    cmd_valid_i = 1'b1; cmd_instr_i = 8'd1; cmd_addr_i = 24'h000040; cmd_value_i = 32'h11112222;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("rst_mid_wr.req_before", bus_req_o, 1'b1);
    #2 rst_i = 1'b1;
    #1 check_all_zero("rst_mid_wr");
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    run_cmd(8'd1, 24'h000044, 32'h33334444, 0, 0, 32'h0, 32'h0, 0, "write_after_rst");
    run_cmd(8'd3, 24'h0, 32'h55556666, 0, 1, 32'h0, 32'h77778888, 0, "stream_after_rst");

    // Timeout, then recovery.
    run_cmd(8'd2, 24'h000030, 32'h0, TO - 1, 0, 32'hDEADBEEF, 32'h0, 0, "read_timeout");
    run_cmd(8'd2, 24'h000034, 32'h0, 0, 0, 32'h0BADF00D, 32'h0, 0, "read_clears_err");
    run_cmd(8'd3, 24'h0, 32'h99990000, TO - 1, 0, 32'h0, 32'h12121212, 0, "stream_wr_timeout");
    run_cmd(8'd3, 24'h0, 32'h99990001, 0, TO - 1, 0, 32'h34343434, 0, "stream_rd_timeout");

    // Overrun during a READ, then an unknown opcode leaves err set.
    run_cmd(8'd2, 24'h000050, 32'h0, 1, 0, 32'hA5A5A5A5, 32'h0, 1, "read_overrun");
    run_cmd(8'd9, 24'h000060, 32'h0, 0, 0, 32'h0, 32'h0, 0, "unknown_op");
    run_cmd(8'd0, 24'h000061, 32'h0, 0, 0, 32'h0, 32'h0, 0, "zero_op");
    // Overrun landing on the completion cycle is still dropped.
    run_cmd(8'd1, 24'h000070, 32'h5A5A5A5A, 0, 0, 32'h0, 32'h0, 1, "write_overrun_last");

    // Randomized command stream.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3, 4, 5: op = IW'(sel + 1);
        6, 7:             op = 8'd3;
        8:                op = 8'd2;
        9:                op = 8'd0;
        default:          op = IW'($urandom_range(7, 255));
      endcase
      addr = ($urandom_range(0, 3) == 0) ? AW'(24'hFFFFFF - AW'($urandom_range(0, 2)))
                                         : AW'($urandom);
      run_cmd(op, addr, $urandom, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
              $urandom, $urandom,
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
